// File: rtl/mergesort_pkg.sv
// ============================================================================
// Module      : mergesort_pkg
// Description : Shared types and constants for the merge sorter and its
//               stream reader (state encoding, index width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mergesort_pkg;

    localparam int c_default_numvals = 32;
    localparam int c_default_size    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } msr_state_t;

    // Rank width for a 2*numvals element stream; never narrower than one bit.
    function automatic int msr_idx_w(input int numvals);
        return (2 * numvals <= 2) ? 1 : $clog2(2 * numvals);
    endfunction

endpackage : mergesort_pkg

`default_nettype wire

// File: rtl/msr_order_checker.sv
// ============================================================================
// Module      : msr_order_checker
// Description : Remembers the last accepted element and raises a sticky flag
//               when an accepted element is smaller than its predecessor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msr_order_checker #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_accept,
    input  logic            i_first,
    input  logic [SIZE-1:0] i_data,
    output logic            o_order_err
);

    logic [SIZE-1:0] r_prev_q, w_prev_d;
    logic            r_err_q,  w_err_d;

    always_comb begin
        w_prev_d = r_prev_q;
        w_err_d  = r_err_q;
        if (i_clear) begin
            w_err_d = 1'b0;
        end else if (i_accept) begin
            w_prev_d = i_data;
            // Rank 0 has no predecessor; equal neighbours are legal.
            if (!i_first && (i_data < r_prev_q)) begin
                w_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
            r_err_q  <= w_err_d;
        end
    end

    assign o_order_err = r_err_q;

endmodule : msr_order_checker

`default_nettype wire

// File: rtl/mergesort_stream_reader.sv
// ============================================================================
// Module      : mergesort_stream_reader
// Description : Captures the sorter's 2*NUMVALS result vector on start and
//               streams it rank 0 first over valid/ready, then pulses done.
//               Optional ordering check enabled by MSR_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mergesort_stream_reader
    import mergesort_pkg::*;
#(
    parameter  int NUMVALS = c_default_numvals,
    parameter  int SIZE    = c_default_size,
    localparam int IDX_W   = msr_idx_w(NUMVALS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2*NUMVALS*SIZE-1:0] sorted_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE-1:0]           out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      done,
    output logic                      order_err
);

    localparam int               c_nelem    = 2 * NUMVALS;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(c_nelem - 1);

    msr_state_t       r_state_q, w_state_d;
    logic [IDX_W-1:0] r_index_q, w_index_d;
    logic [SIZE-1:0]  r_mem_q [c_nelem];
    logic [SIZE-1:0]  w_mem_d [c_nelem];
    logic             w_is_last;

    always_comb begin
        w_state_d = r_state_q;
        w_index_d = r_index_q;
        w_mem_d   = r_mem_q;
        w_is_last = (r_index_q == c_last_idx);
        busy      = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        done      = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    for (int k = 0; k < c_nelem; k++) begin
                        w_mem_d[k] = sorted_in[k*SIZE +: SIZE];
                    end
                    w_index_d = '0;
                    w_state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = r_mem_q[r_index_q];
                out_idx   = r_index_q;
                out_last  = w_is_last;
                // Leaving on the last rank keeps the index from ever wrapping.
                if (out_ready) begin
                    if (w_is_last) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_index_d = r_index_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_index_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_index_q <= w_index_d;
        end
    end

    for (genvar k = 0; k < c_nelem; k++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_mem_q[k] <= '0;
            end else begin
                r_mem_q[k] <= w_mem_d[k];
            end
        end
    end

`ifdef MSR_ORDER_CHECK_EN
    msr_order_checker #(
        .SIZE (SIZE)
    ) u_order_checker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     ((r_state_q == ST_IDLE) && start),
        .i_accept    (out_valid && out_ready),
        .i_first     (r_index_q == '0),
        .i_data      (out_data),
        .o_order_err (order_err)
    );
`else
    assign order_err = 1'b0;
`endif

endmodule : mergesort_stream_reader

`default_nettype wire

// File: tb/tb_mergesort_stream_reader.sv
// ============================================================================
// Module      : tb_mergesort_stream_reader
// Description : Directed self-checking bench for mergesort_stream_reader
//               (NUMVALS=4/SIZE=8 and NUMVALS=3/SIZE=16 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mergesort_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start = 1'b0;
    logic [63:0] sin   = '0;
    logic        ready = 1'b1;
    logic        busy, valid, last, done, oerr;
    logic [7:0]  data;
    logic [2:0]  idx;

    logic        start2 = 1'b0;
    logic [95:0] sin2   = '0;
    logic        ready2 = 1'b1;
    logic        busy2, valid2, last2, done2, oerr2;
    logic [15:0] data2;
    logic [2:0]  idx2;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  v_basic [8] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};
    logic [7:0]  v_other [8] = '{8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94, 8'd93, 8'd92};
    logic [7:0]  v_order [8] = '{8'd4, 8'd4, 8'd7, 8'd6, 8'd9, 8'd9, 8'd9, 8'd10};
    logic [15:0] v_odd   [6] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd65535};

    always #5 clk = ~clk;

    mergesort_stream_reader #(.NUMVALS(4), .SIZE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sorted_in(sin), .busy(busy),
        .out_valid(valid), .out_ready(ready), .out_data(data), .out_idx(idx),
        .out_last(last), .done(done), .order_err(oerr)
    );

    mergesort_stream_reader #(.NUMVALS(3), .SIZE(16)) dut_odd (
        .clk(clk), .rst(rst), .start(start2), .sorted_in(sin2), .busy(busy2),
        .out_valid(valid2), .out_ready(ready2), .out_data(data2), .out_idx(idx2),
        .out_last(last2), .done(done2), .order_err(oerr2)
    );

    function automatic logic [63:0] pack8(input logic [7:0] v [8]);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = v[k];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of the first beat cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, valid, data, idx, last, done, oerr} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 0", {busy, valid, data, idx, last, done, oerr});
        end
        n_vec++;
        if ({busy2, valid2, data2, idx2, last2, done2, oerr2} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs_odd got %b want 0", {busy2, valid2, data2, idx2, last2, done2, oerr2});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_stream();
        ready = 1'b1;
        sin = pack8(v_basic);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({valid, data, idx, last, oerr} !== {1'b1, v_basic[i], 3'(i), (i == 7), 1'b0}) begin
                n_err++;
                $display("FAIL basic_beat%0d got v=%b d=%0d i=%0d l=%b e=%b want d=%0d", i, valid, data, idx, last, oerr, v_basic[i]);
            end
            step();
        end
        n_vec++;
        if ({done, valid, busy, oerr} !== 4'b1010) begin
            n_err++;
            $display("FAIL basic_done got done/valid/busy/err=%b want 1010", {done, valid, busy, oerr});
        end
        step();
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_idle got done/busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int cyc   = 0;
        sin = pack8(v_basic);
        pulse_start();
        while (beats < 8 && cyc < 64) begin
            ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            n_vec++;
            if ({valid, data, idx, last, done} !== {1'b1, v_basic[beats], 3'(beats), (beats == 7), 1'b0}) begin
                n_err++;
                $display("FAIL bp_cyc%0d got v=%b d=%0d i=%0d l=%b want d=%0d i=%0d", cyc, valid, data, idx, last, v_basic[beats], beats);
            end
            if (ready) beats++;
            cyc++;
            step();
        end
        n_vec++;
        if (beats != 8) begin
            n_err++;
            $display("FAIL bp_timeout got %0d beats want 8", beats);
        end
        n_vec++;
        if ({done, valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_done got done/valid=%b want 10", {done, valid});
        end
        ready = 1'b1;
        step();
    endtask

    task automatic test_restart_and_input_change();
        ready = 1'b1;
        sin = pack8(v_basic);
        pulse_start();
        sin = pack8(v_other);
        for (int i = 0; i < 8; i++) begin
            start = (i == 3);
            n_vec++;
            if ({valid, data, idx, last} !== {1'b1, v_basic[i], 3'(i), (i == 7)}) begin
                n_err++;
                $display("FAIL restart_beat%0d got v=%b d=%0d i=%0d l=%b want d=%0d", i, valid, data, idx, last, v_basic[i]);
            end
            step();
        end
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_done got %b want 1", done);
        end
        step();
        n_vec++;
        if ({busy, valid} !== 2'b00) begin
            n_err++;
            $display("FAIL restart_idle got busy/valid=%b want 00", {busy, valid});
        end
    endtask

    task automatic test_reset_mid_transfer();
        ready = 1'b1;
        sin = pack8(v_basic);
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_vec++;
        if ({busy, valid, done, idx} !== 6'd0) begin
            n_err++;
            $display("FAIL midreset_state got busy/valid/done/idx=%b want 0", {busy, valid, done, idx});
        end
        step();
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_nodone got busy/done=%b want 00", {busy, done});
        end
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({valid, data, idx} !== {1'b1, v_basic[i], 3'(i)}) begin
                n_err++;
                $display("FAIL midreset_beat%0d got v=%b d=%0d i=%0d want d=%0d", i, valid, data, idx, v_basic[i]);
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_order_check();
        logic en;
`ifdef MSR_ORDER_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        ready = 1'b1;
        sin = pack8(v_order);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({data, oerr} !== {v_order[i], en & (i >= 4)}) begin
                n_err++;
                $display("FAIL order_beat%0d got d=%0d err=%b want d=%0d err=%b", i, data, oerr, v_order[i], en & (i >= 4));
            end
            step();
        end
        n_vec++;
        if ({done, oerr} !== {1'b1, en}) begin
            n_err++;
            $display("FAIL order_done got done/err=%b want %b", {done, oerr}, {1'b1, en});
        end
        step();
        n_vec++;
        if (oerr !== en) begin
            n_err++;
            $display("FAIL order_hold got %b want %b", oerr, en);
        end
        sin = pack8(v_basic);
        pulse_start();
        n_vec++;
        if (oerr !== 1'b0) begin
            n_err++;
            $display("FAIL order_clear got %b want 0", oerr);
        end
        for (int i = 0; i < 8; i++) step();
        n_vec++;
        if ({done, oerr} !== 2'b10) begin
            n_err++;
            $display("FAIL order_clean_done got done/err=%b want 10", {done, oerr});
        end
        step();
    endtask

    task automatic test_odd_sizing();
        ready2 = 1'b1;
        for (int k = 0; k < 6; k++) sin2[k*16 +: 16] = v_odd[k];
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({valid2, data2, idx2, last2} !== {1'b1, v_odd[i], 3'(i), (i == 5)}) begin
                n_err++;
                $display("FAIL odd_beat%0d got v=%b d=%0d i=%0d l=%b want d=%0d", i, valid2, data2, idx2, last2, v_odd[i]);
            end
            step();
        end
        n_vec++;
        if ({done2, valid2, oerr2} !== 3'b100) begin
            n_err++;
            $display("FAIL odd_done got done/valid/err=%b want 100", {done2, valid2, oerr2});
        end
        step();
        n_vec++;
        if ({done2, busy2} !== 2'b00) begin
            n_err++;
            $display("FAIL odd_idle got done/busy=%b want 00", {done2, busy2});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_restart_and_input_change();
        test_reset_mid_transfer();
        test_order_check();
        test_odd_sizing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mergesort_stream_reader

`default_nettype wire
